// File: rtl/tx_retry_controller.sv
// Packet retransmission sequencer: launches a transmit, waits for ack/nak or timeout,
// and retries after a backoff gap until success or the retry budget is spent.
module tx_retry_controller #(
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned BACKOFF     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic       abort,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       ack_pulse,
    input  logic       nak_pulse,
    output logic       tx_start,
    output logic [3:0] attempt_cnt,
    output logic [2:0] ctl_state,
    output logic       busy,
    output logic       done_ok,
    output logic       done_fail
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StWaitDone = 3'd2,
        StWaitAck  = 3'd3,
        StBackoff  = 3'd4,
        StSuccess  = 3'd5,
        StFail     = 3'd6
    } state_e;

    // One timer serves both the ack window and the backoff gap.
    localparam int unsigned TMAX = (ACK_TIMEOUT > BACKOFF) ? ACK_TIMEOUT : BACKOFF;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BO_LAST  = TW'(BACKOFF - 1);
    localparam logic [3:0]    MAX_CNT  = 4'(MAX_RETRY);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    attempt_d;
    logic          req_prev_q;
    logic          req_edge;
    logic          start_d;
    logic          ok_d;
    logic          fail_d;
    logic          busy_d;

    assign req_edge  = send_req & ~req_prev_q;
    assign ctl_state = state_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        attempt_d = attempt_cnt;
        start_d   = 1'b0;
        ok_d      = done_ok;
        fail_d    = done_fail;

        case (state_q)
            StIdle, StSuccess, StFail: begin
                if (req_edge) begin
                    state_d   = StStart;
                    attempt_d = 4'd0;
                    ok_d      = 1'b0;
                    fail_d    = 1'b0;
                end
            end
            StStart: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!tx_busy) begin
                    start_d = 1'b1;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (tx_done) begin
                    state_d = StWaitAck;
                    timer_d = '0;
                end
            end
            StWaitAck: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ack_pulse) begin
                    state_d = StSuccess;
                    ok_d    = 1'b1;
                end else if (nak_pulse || (timer_q == ACK_LAST)) begin
                    if (attempt_cnt < MAX_CNT) begin
                        attempt_d = attempt_cnt + 4'd1;
                        timer_d   = '0;
                        state_d   = StBackoff;
                    end else begin
                        state_d = StFail;
                        fail_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StBackoff: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (timer_q == BO_LAST) begin
                    state_d = StStart;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StStart) || (state_d == StWaitDone) ||
                 (state_d == StWaitAck) || (state_d == StBackoff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            attempt_cnt <= 4'd0;
            req_prev_q  <= 1'b1;  // a level held through reset is not an edge
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done_ok     <= 1'b0;
            done_fail   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            attempt_cnt <= attempt_d;
            req_prev_q  <= send_req;
            tx_start    <= start_d;
            busy        <= busy_d;
            done_ok     <= ok_d;
            done_fail   <= fail_d;
        end
    end

endmodule

// File: tb/tb_tx_retry_controller.sv
// Directed bench for tx_retry_controller with MAX_RETRY=2, ACK_TIMEOUT=8, BACKOFF=4.
module tb_tx_retry_controller;

    logic       clk = 1'b0;
    logic       rst_n, send_req, abort, tx_busy, tx_done, ack_pulse, nak_pulse;
    logic       tx_start, busy, done_ok, done_fail;
    logic [3:0] attempt_cnt;
    logic [2:0] ctl_state;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    always #5 clk = ~clk;

    tx_retry_controller #(
        .MAX_RETRY  (2),
        .ACK_TIMEOUT(8),
        .BACKOFF    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_req   (send_req),
        .abort      (abort),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .ack_pulse  (ack_pulse),
        .nak_pulse  (nak_pulse),
        .tx_start   (tx_start),
        .attempt_cnt(attempt_cnt),
        .ctl_state  (ctl_state),
        .busy       (busy),
        .done_ok    (done_ok),
        .done_fail  (done_fail)
    );

    typedef struct {
        logic       rst, snd, bsy, dn, ack, nak, abt;
        logic [2:0] st;
        logic       start, bz, ok, fl;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_start) starts++;
    endtask

    task automatic idle_inputs();
        send_req = 1'b0; abort = 1'b0; tx_busy = 1'b0;
        tx_done = 1'b0; ack_pulse = 1'b0; nak_pulse = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        starts = 0;
    endtask

    // Request edge followed by the first launch; leaves the DUT in WAIT_DONE.
    task automatic launch(input string tag);
        send_req = 1'b1; tick();
        check({tag, " start state"}, ctl_state, 1);
        send_req = 1'b0; tick();
        check({tag, " first pulse"}, tx_start, 1);
    endtask

    initial begin
        // rst snd bsy dn ack nak abt | st start busy ok fail cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 18; i++) begin
            rst_n = vecs[i].rst; send_req = vecs[i].snd; tx_busy = vecs[i].bsy;
            tx_done = vecs[i].dn; ack_pulse = vecs[i].ack; nak_pulse = vecs[i].nak;
            abort = vecs[i].abt;
            tick();
            check($sformatf("vec%0d state", i), ctl_state, vecs[i].st);
            check($sformatf("vec%0d tx_start", i), tx_start, vecs[i].start);
            check($sformatf("vec%0d busy", i), busy, vecs[i].bz);
            check($sformatf("vec%0d done_ok", i), done_ok, vecs[i].ok);
            check($sformatf("vec%0d done_fail", i), done_fail, vecs[i].fl);
            check($sformatf("vec%0d attempt_cnt", i), attempt_cnt, vecs[i].cnt);
        end
        check("table pulse count", starts, 1);

        // Every attempt rejected: three launches, then FAIL.
        reset_dut();
        launch("nak");
        for (int a = 0; a < 3; a++) begin
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            check($sformatf("nak%0d wait_ack", a), ctl_state, 3);
            nak_pulse = 1'b1; tick(); nak_pulse = 1'b0;
            if (a < 2) begin
                check($sformatf("nak%0d backoff", a), ctl_state, 4);
                check($sformatf("nak%0d cnt", a), attempt_cnt, a + 1);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check($sformatf("nak%0d gap%0d state", a, k), ctl_state, 4);
                    check($sformatf("nak%0d gap%0d pulse", a, k), tx_start, 0);
                end
                tick();
                check($sformatf("nak%0d restart", a), ctl_state, 1);
                check($sformatf("nak%0d restart pulse", a), tx_start, 0);
                tick();
                check($sformatf("nak%0d relaunch", a), tx_start, 1);
            end
        end
        check("nak final state", ctl_state, 6);
        check("nak done_fail", done_fail, 1);
        check("nak done_ok", done_ok, 0);
        check("nak attempt_cnt", attempt_cnt, 2);
        check("nak busy", busy, 0);
        check("nak pulse count", starts, 3);

        // Silent receiver: timeout 8 cycles after WAIT_ACK entry, then ack+nak together.
        reset_dut();
        launch("tmo");
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("tmo wait%0d", k), ctl_state, 3);
        end
        tick();
        check("tmo backoff", ctl_state, 4);
        check("tmo cnt", attempt_cnt, 1);
        for (int k = 0; k < 4; k++) tick();
        check("tmo restart", ctl_state, 1);
        tick();
        check("tmo relaunch", tx_start, 1);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ack_pulse = 1'b1; nak_pulse = 1'b1; tick();
        ack_pulse = 1'b0; nak_pulse = 1'b0;
        check("tmo ack wins state", ctl_state, 5);
        check("tmo ack wins ok", done_ok, 1);
        check("tmo ack wins cnt", attempt_cnt, 1);

        // Transmitter still busy at START.
        reset_dut();
        tx_busy = 1'b1;
        send_req = 1'b1; tick(); send_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("bsy hold%0d state", k), ctl_state, 1);
            check($sformatf("bsy hold%0d pulse", k), tx_start, 0);
        end
        tx_busy = 1'b0; tick();
        check("bsy release pulse", tx_start, 1);
        check("bsy release state", ctl_state, 2);
        tick();
        check("bsy pulse width", tx_start, 0);
        check("bsy pulse count", starts, 1);

        // Second request ignored in WAIT_DONE; abort in BACKOFF.
        reset_dut();
        launch("abt");
        tick();
        send_req = 1'b1; tick(); send_req = 1'b0;
        check("abt ignored edge", ctl_state, 2);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        nak_pulse = 1'b1; tick(); nak_pulse = 1'b0;
        check("abt backoff", ctl_state, 4);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abt idle", ctl_state, 0);
        check("abt busy", busy, 0);
        check("abt cnt kept", attempt_cnt, 1);
        check("abt flags", {done_ok, done_fail}, 0);
        for (int k = 0; k < 8; k++) tick();
        check("abt still idle", ctl_state, 0);
        check("abt pulse count", starts, 1);

        // send_req held high through reset release.
        rst_n = 1'b0; send_req = 1'b1; tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rel held idle", ctl_state, 0);
        check("rel held busy", busy, 0);
        send_req = 1'b0; tick();

        // Reset cuts a pending tx_start.
        send_req = 1'b1; tick(); send_req = 1'b0;
        check("cut start", ctl_state, 1);
        rst_n = 1'b0; tick();
        check("cut pulse", tx_start, 0);
        check("cut state", ctl_state, 0);
        rst_n = 1'b1; tick();

        // Reset while in WAIT_ACK after a retry.
        starts = 0;
        launch("rw");
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        nak_pulse = 1'b1; tick(); nak_pulse = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        check("rw wait_ack", ctl_state, 3);
        check("rw cnt before", attempt_cnt, 1);
        rst_n = 1'b0; tick();
        check("rw outputs zero",
              {tx_start, attempt_cnt, ctl_state, busy, done_ok, done_fail}, 0);
        rst_n = 1'b1; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
